// File: rtl/pipelined_shifter.sv
// ============================================================================
//  Module   : pipelined_shifter
//  Purpose  : Elastic, pipelined barrel shifter/rotator (SLL/SRL/SRA/ROL/ROR).
//             Optional macro PIPELINED_SHIFTER_SRA_EN enables sign-filling SRA.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAGW   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [WIDTH-1:0]         X,
    input  logic [$clog2(WIDTH)-1:0] Amt,
    input  logic [2:0]               Mode,
    input  logic [TAGW-1:0]          InTag,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [WIDTH-1:0]         Y,
    output logic [TAGW-1:0]          OutTag
);

    localparam int             c_lvls  = $clog2(WIDTH);
    localparam logic [c_lvls:0] c_width = (c_lvls + 1)'(WIDTH);
    localparam logic [2:0]     c_sll   = 3'd0;
    localparam logic [2:0]     c_srl   = 3'd1;
    localparam logic [2:0]     c_sra   = 3'd2;
    localparam logic [2:0]     c_rol   = 3'd3;
    localparam logic [2:0]     c_ror   = 3'd4;

    logic              valid_q [STAGES];
    logic              valid_d [STAGES];
    logic [WIDTH-1:0]  data_q  [STAGES];
    logic [WIDTH-1:0]  data_d  [STAGES];
    logic [c_lvls-1:0] amt_q   [STAGES];
    logic [c_lvls-1:0] amt_d   [STAGES];
    logic [2:0]        mode_q  [STAGES];
    logic [2:0]        mode_d  [STAGES];
    logic [TAGW-1:0]   tag_q   [STAGES];
    logic [TAGW-1:0]   tag_d   [STAGES];

    logic [STAGES-1:0] w_adv;
    logic              w_in_fire;
    logic [WIDTH-1:0]  w_x_in;
    logic [c_lvls-1:0] w_amt_in;
    logic [2:0]        w_mode_in;
    logic              w_amt_big;
    logic [c_lvls:0]   w_amt_sub;

    function automatic logic [WIDTH-1:0] level_shift(input logic [WIDTH-1:0] d,
                                                     input logic [2:0]       m,
                                                     input int               sh);
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            c_sll:   r = d << sh;
            c_srl:   r = d >> sh;
`ifdef PIPELINED_SHIFTER_SRA_EN
            c_sra:   r = WIDTH'($signed(d) >>> sh);
`endif
            c_rol:   r = (d << sh) | (d >> (WIDTH - sh));
            c_ror:   r = (d >> sh) | (d << (WIDTH - sh));
            default: r = d;
        endcase
        return r;
    endfunction

    // Apply only the barrel levels that belong to register stage s.
    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0]  d,
                                                     input logic [2:0]        m,
                                                     input logic [c_lvls-1:0] a,
                                                     input int                s);
        logic [WIDTH-1:0] r;
        r = d;
        for (int k = 0; k < c_lvls; k++) begin
            if (((k * STAGES) / c_lvls) == s && a[k]) begin
                r = level_shift(r, m, 1 << k);
            end
        end
        return r;
    endfunction

    // Out-of-range amounts are resolved up front so the levels only see amt < WIDTH.
    always_comb begin
        w_mode_in = Mode;
`ifndef PIPELINED_SHIFTER_SRA_EN
        if (Mode == c_sra) begin
            w_mode_in = c_srl;
        end
`endif
        w_x_in    = X;
        w_amt_in  = Amt;
        w_amt_big = ({1'b0, Amt} >= c_width);
        w_amt_sub = {1'b0, Amt} - c_width;
        if (w_mode_in > c_ror) begin
            w_amt_in = '0;
        end else if (w_amt_big) begin
            if (w_mode_in == c_rol || w_mode_in == c_ror) begin
                w_amt_in = w_amt_sub[c_lvls-1:0];
            end else begin
                w_amt_in = '0;
                w_x_in   = '0;
`ifdef PIPELINED_SHIFTER_SRA_EN
                if (w_mode_in == c_sra) begin
                    w_x_in = {WIDTH{X[WIDTH-1]}};
                end
`endif
            end
        end
    end

    // A stage advances if it or any later stage is empty, or the sink is ready.
    always_comb begin
        w_adv = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_adv[i] = OutReady;
            for (int j = i; j < STAGES; j++) begin
                if (!valid_q[j]) begin
                    w_adv[i] = 1'b1;
                end
            end
        end
    end

    assign InReady   = !reset && w_adv[0];
    assign w_in_fire = InValid && InReady;

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            valid_d[s] = valid_q[s];
            data_d[s]  = data_q[s];
            amt_d[s]   = amt_q[s];
            mode_d[s]  = mode_q[s];
            tag_d[s]   = tag_q[s];
        end
        if (w_adv[0]) begin
            valid_d[0] = w_in_fire;
            if (w_in_fire) begin
                data_d[0] = stage_shift(w_x_in, w_mode_in, w_amt_in, 0);
                amt_d[0]  = w_amt_in;
                mode_d[0] = w_mode_in;
                tag_d[0]  = InTag;
            end
        end
        for (int s = 1; s < STAGES; s++) begin
            if (w_adv[s]) begin
                valid_d[s] = valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_d[s] = stage_shift(data_q[s-1], mode_q[s-1], amt_q[s-1], s);
                    amt_d[s]  = amt_q[s-1];
                    mode_d[s] = mode_q[s-1];
                    tag_d[s]  = tag_q[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
                amt_q[s]   <= '0;
                mode_q[s]  <= '0;
                tag_q[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= valid_d[s];
                data_q[s]  <= data_d[s];
                amt_q[s]   <= amt_d[s];
                mode_q[s]  <= mode_d[s];
                tag_q[s]   <= tag_d[s];
            end
        end
    end

    assign OutValid = valid_q[STAGES-1];
    assign Y        = data_q[STAGES-1];
    assign OutTag   = tag_q[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
// ============================================================================
//  Module   : tb_pipelined_shifter
//  Purpose  : Self-checking bench for pipelined_shifter (8-bit/2-stage and
//             6-bit/3-stage instances) against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipelined_shifter;

`ifdef PIPELINED_SHIFTER_SRA_EN
    localparam bit c_sra_en = 1'b1;
`else
    localparam bit c_sra_en = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] x, y;
    logic [2:0] amt, mode;
    logic [3:0] in_tag, out_tag;

    logic       in_valid6, in_ready6, out_valid6, out_ready6;
    logic [5:0] x6, y6;
    logic [2:0] amt6, mode6;
    logic [3:0] in_tag6, out_tag6;

    int total = 0;
    int bad   = 0;
    int in_cnt = 0;
    int out_cnt = 0;

    typedef struct {
        logic [7:0] y;
        logic [3:0] tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(8), .STAGES(2), .TAGW(4)) dut (
        .clk(clk), .reset(reset), .InValid(in_valid), .InReady(in_ready),
        .X(x), .Amt(amt), .Mode(mode), .InTag(in_tag),
        .OutValid(out_valid), .OutReady(out_ready), .Y(y), .OutTag(out_tag)
    );

    pipelined_shifter #(.WIDTH(6), .STAGES(3), .TAGW(4)) dut6 (
        .clk(clk), .reset(reset), .InValid(in_valid6), .InReady(in_ready6),
        .X(x6), .Amt(amt6), .Mode(mode6), .InTag(in_tag6),
        .OutValid(out_valid6), .OutReady(out_ready6), .Y(y6), .OutTag(out_tag6)
    );

    // Reference: shift/rotate rules stated directly on integers.
    function automatic int ref_y(int xv, int av, int mv, int w);
        int mask, sgn, v, r, m;
        mask = (1 << w) - 1;
        sgn  = (xv >> (w - 1)) & 1;
        m    = (mv == 2 && !c_sra_en) ? 1 : mv;
        case (m)
            0: ref_y = (av >= w) ? 0 : ((xv << av) & mask);
            1: ref_y = (av >= w) ? 0 : (xv >> av);
            2: begin
                if (av >= w) ref_y = sgn ? mask : 0;
                else begin
                    v = sgn ? xv - (1 << w) : xv;
                    ref_y = (v >>> av) & mask;
                end
            end
            3: begin r = av % w; ref_y = ((xv << r) | (xv >> (w - r))) & mask; end
            4: begin r = av % w; ref_y = ((xv >> r) | (xv << (w - r))) & mask; end
            default: ref_y = xv;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard and hold-stability checking on every falling edge.
    logic       stall_prev = 1'b0;
    logic [7:0] prev_y;
    logic [3:0] prev_tag;
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            in_cnt = out_cnt;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                chk("hold_y", y, prev_y);
                chk("hold_tag", out_tag, prev_tag);
            end
            if (in_valid && in_ready) begin
                sb.push_back('{8'(ref_y(x, amt, mode, 8)), in_tag});
                in_cnt++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("stream_y", y, e.y);
                    chk("stream_tag", out_tag, e.tag);
                end
                out_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            prev_y     = y;
            prev_tag   = out_tag;
        end
    end

    task automatic set_in(input logic [7:0] xv, input logic [2:0] av,
                          input logic [2:0] mv, input logic [3:0] tv);
        in_valid = 1'b1; x = xv; amt = av; mode = mv; in_tag = tv;
    endtask

    task automatic send(input logic [7:0] xv, input logic [2:0] av,
                        input logic [2:0] mv, input logic [3:0] tv);
        int  n;
        logic ok;
        n = 0;
        set_in(xv, av, mv, tv);
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    // Single op on an empty 8-bit pipe with literal result and latency.
    task automatic run8(input string name, input logic [7:0] xv, input logic [2:0] av,
                        input logic [2:0] mv, input logic [3:0] tv, input logic [7:0] ey);
        out_ready = 1'b1;
        set_in(xv, av, mv, tv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_early"}, out_valid, 0);
        @(posedge clk); #1;
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_y"}, y, ey);
        chk({name, "_tag"}, out_tag, tv);
        @(posedge clk); #1;
    endtask

    task automatic run6(input string name, input logic [5:0] xv, input logic [2:0] av,
                        input logic [2:0] mv, input logic [5:0] ey);
        in_valid6 = 1'b1; x6 = xv; amt6 = av; mode6 = mv; in_tag6 = 4'h9;
        @(posedge clk); #1;
        in_valid6 = 1'b0;
        @(posedge clk); #1;
        chk({name, "_early"}, out_valid6, 0);
        @(posedge clk); #1;
        chk({name, "_valid"}, out_valid6, 1);
        chk({name, "_y"}, y6, ey);
        chk({name, "_tag"}, out_tag6, 4'h9);
    endtask

    logic done;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; amt = '0; mode = '0; in_tag = '0;
        in_valid6 = 1'b0; out_ready6 = 1'b1; x6 = '0; amt6 = '0; mode6 = '0; in_tag6 = '0;
        done = 1'b0;

        // Model pins
        chk("model_rol", ref_y(8'h96, 3, 3, 8), 8'hB4);
        chk("model_ror6", ref_y(6'b000001, 7, 4, 6), 6'b100000);
        chk("model_sra8", ref_y(8'h80, 7, 2, 8), c_sra_en ? 8'hFF : 8'h01);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_tag", out_tag, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed single operations
        run8("rol", 8'h96, 3'd3, 3'd3, 4'h5, 8'hB4);
        run8("sra", 8'h80, 3'd7, 3'd2, 4'h6, c_sra_en ? 8'hFF : 8'h01);
        run8("sll", 8'h01, 3'd7, 3'd0, 4'h7, 8'h80);
        run8("srl", 8'hF0, 3'd4, 3'd1, 4'h8, 8'h0F);
        run8("ror", 8'h01, 3'd1, 3'd4, 4'hA, 8'h80);
        run8("pass", 8'h5A, 3'd3, 3'd5, 4'hB, 8'h5A);
        run6("ror6", 6'b000001, 3'd7, 3'd4, 6'b100000);
        run6("sll6", 6'b000001, 3'd7, 3'd0, 6'b000000);
        run6("sra6", 6'b100000, 3'd6, 3'd2, c_sra_en ? 6'b111111 : 6'b000000);
        @(posedge clk); #1;

        // Backpressure: two accepts fill the pipe, then hold for five cycles total
        out_ready = 1'b0;
        set_in(8'h11, 3'd1, 3'd3, 4'd1);
        @(posedge clk); #1;
        set_in(8'h22, 3'd2, 3'd3, 4'd2);
        @(posedge clk); #1;
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_full_out_valid", out_valid, 1);
        chk("bp_full_tag", out_tag, 1);
        set_in(8'h33, 3'd3, 3'd3, 4'd3);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_stall_in_ready", in_ready, 0);
            chk("bp_stall_tag", out_tag, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_no_bubble", in_ready, 1);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("bp_drain_valid", out_valid, 1);
            chk("bp_drain_tag", out_tag, 4'(j));
            @(posedge clk); #1;
            if (j == 1) set_in(8'h44, 3'd4, 3'd3, 4'd4);
            if (j == 2) in_valid = 1'b0;
        end
        @(posedge clk); #1;

        // Reset with two operations in flight
        set_in(8'hAA, 3'd1, 3'd0, 4'd5);
        @(posedge clk); #1;
        set_in(8'hBB, 3'd2, 3'd1, 4'd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_y", y, 0);
        chk("midrst_tag", out_tag, 0);
        chk("midrst_in_ready_after", in_ready, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_ghost", out_valid, 0);
        end
        run8("after_rst", 8'h0F, 3'd4, 3'd0, 4'hC, 8'hF0);

        // Random stream with random backpressure
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'(i));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("stream_drained", sb.size(), 0);
        chk("stream_count", out_cnt, in_cnt);
        chk("stream_idle", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
